// File: rtl/itree_sched_pkg.sv
// Shared types and helpers for the isolation-tree channel scheduler.
package itree_sched_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_REPORT = 2'd2
    } sched_state_t;

    // Default frame width, matches the engine data_input width
    localparam int DATA_W_DEF = 8;

    // Width of a channel index; at least one bit
    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/itree_rr_arbiter.sv
// Combinational round-robin pick: first requester after rr_ptr, cyclic.
module itree_rr_arbiter
    import itree_sched_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = ch_w(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] rr_ptr,
    output logic [N_CH-1:0] gnt,
    output logic [CH_W-1:0] gnt_idx,
    output logic            any
);

    int w_c;

    // Scan offsets 1..N_CH from the pointer; the pointer itself is checked last
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        w_c     = 0;
        for (int off = 1; off <= N_CH; off++) begin
            w_c = (int'(rr_ptr) + off) % N_CH;
            if (!any && (|(req & (N_CH'(1) << w_c)))) begin
                any     = 1'b1;
                gnt_idx = CH_W'(w_c);
                gnt     = N_CH'(1) << w_c;
            end
        end
    end

endmodule

// File: rtl/itree_channel_scheduler.sv
// Round-robin scheduler sharing one isolation-tree engine between channels.
// Optional engine watchdog: define ITREE_SCHED_TIMEOUT_EN.
module itree_channel_scheduler
    import itree_sched_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 255,
    parameter int CH_W        = ch_w(N_CH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_CH-1:0]        ch_valid,
    input  logic [N_CH*DATA_W-1:0] ch_data,
    output logic [N_CH-1:0]        ch_ack,
    output logic [DATA_W-1:0]      eng_data,
    output logic                   eng_valid,
    input  logic                   eng_done,
    input  logic                   eng_anomaly,
    output logic                   res_valid,
    output logic [CH_W-1:0]        res_ch,
    output logic                   res_anomaly,
    output logic                   res_timeout,
    output logic [N_CH-1:0]        anomaly_flags,
    input  logic [N_CH-1:0]        flag_clr,
    output logic                   busy
);

    sched_state_t        r_state;
    logic [CH_W-1:0]     r_rr_ptr;
    logic [CH_W-1:0]     r_gnt_idx;
    logic [N_CH-1:0]     r_ch_ack;
    logic [DATA_W-1:0]   r_eng_data;
    logic                r_eng_valid;
    logic                r_res_valid;
    logic [CH_W-1:0]     r_res_ch;
    logic                r_res_anomaly;
    logic [N_CH-1:0]     r_flags;

    logic [N_CH-1:0]     w_gnt;
    logic [CH_W-1:0]     w_gnt_idx;
    logic                w_any;
    logic [DATA_W-1:0]   w_ch_frame [N_CH];
    logic [N_CH-1:0]     w_flag_set;

    // Unpack the flat channel bus into per-channel frames
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
        assign w_ch_frame[gi] = ch_data[gi*DATA_W +: DATA_W];
    end

    itree_rr_arbiter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_arb (
        .req     (ch_valid),
        .rr_ptr  (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

`ifdef ITREE_SCHED_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [TO_W-1:0] r_cnt;
    logic            r_res_timeout;
    assign res_timeout = r_res_timeout;
`else
    // No watchdog in this build; this is constant 0 for any legal limit
    assign res_timeout = (TIMEOUT_CYC < 0);
`endif

    // Grant / issue / report sequencing with registered pulse outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= CH_W'(N_CH - 1);
            r_gnt_idx     <= '0;
            r_ch_ack      <= '0;
            r_eng_data    <= '0;
            r_eng_valid   <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_ch      <= '0;
            r_res_anomaly <= 1'b0;
`ifdef ITREE_SCHED_TIMEOUT_EN
            r_cnt         <= '0;
            r_res_timeout <= 1'b0;
`endif
        end else begin
            r_ch_ack    <= '0;
            r_res_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_eng_data  <= w_ch_frame[w_gnt_idx];
                        r_ch_ack    <= w_gnt;
                        r_eng_valid <= 1'b1;
                        r_gnt_idx   <= w_gnt_idx;
                        r_state     <= S_ISSUE;
`ifdef ITREE_SCHED_TIMEOUT_EN
                        r_cnt       <= '0;
`endif
                    end
                end
                S_ISSUE: begin
                    if (eng_done) begin
                        r_eng_valid   <= 1'b0;
                        r_res_valid   <= 1'b1;
                        r_res_ch      <= r_gnt_idx;
                        r_res_anomaly <= eng_anomaly;
                        r_state       <= S_REPORT;
`ifdef ITREE_SCHED_TIMEOUT_EN
                        r_res_timeout <= 1'b0;
                    end else if (r_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        r_eng_valid   <= 1'b0;
                        r_res_valid   <= 1'b1;
                        r_res_ch      <= r_gnt_idx;
                        r_res_anomaly <= 1'b0;
                        r_res_timeout <= 1'b1;
                        r_state       <= S_REPORT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
`endif
                    end
                end
                S_REPORT: begin
                    r_rr_ptr <= r_gnt_idx;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_flag_set = (r_res_valid && r_res_anomaly) ? (N_CH'(1) << r_res_ch) : '0;

    // Sticky anomaly flags; a set in the result cycle overrides a clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= '0;
        end else begin
            r_flags <= (r_flags & ~flag_clr) | w_flag_set;
        end
    end

    assign ch_ack        = r_ch_ack;
    assign eng_data      = r_eng_data;
    assign eng_valid     = r_eng_valid;
    assign res_valid     = r_res_valid;
    assign res_ch        = r_res_ch;
    assign res_anomaly   = r_res_anomaly;
    assign anomaly_flags = r_flags;
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_itree_channel_scheduler.sv
// Scoreboard bench for itree_channel_scheduler (watchdog case under ITREE_SCHED_TIMEOUT_EN).
`timescale 1ns/1ps
module tb_itree_channel_scheduler;

    localparam int N_CH   = 4;
    localparam int DATA_W = 8;
    localparam int TO_CYC = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [N_CH-1:0]   ch_valid = '0;
    logic [31:0]       ch_data = {8'h44, 8'h33, 8'h22, 8'hA5};
    logic [N_CH-1:0]   ch_ack;
    logic [DATA_W-1:0] eng_data;
    logic              eng_valid;
    logic              eng_done = 1'b0;
    logic              eng_anomaly = 1'b0;
    logic              res_valid;
    logic [1:0]        res_ch;
    logic              res_anomaly;
    logic              res_timeout;
    logic [N_CH-1:0]   anomaly_flags;
    logic [N_CH-1:0]   flag_clr = '0;
    logic              busy;

    typedef struct { int ch; logic [7:0] data; } ack_t;
    typedef struct { int ch; bit anom; bit to; } res_t;
    ack_t ack_q[$];
    res_t res_q[$];

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    itree_channel_scheduler #(
        .N_CH(N_CH), .DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_data(ch_data),
        .ch_ack(ch_ack), .eng_data(eng_data), .eng_valid(eng_valid),
        .eng_done(eng_done), .eng_anomaly(eng_anomaly), .res_valid(res_valid),
        .res_ch(res_ch), .res_anomaly(res_anomaly), .res_timeout(res_timeout),
        .anomaly_flags(anomaly_flags), .flag_clr(flag_clr), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic logic [7:0] data_of(input int ch);
        logic [31:0] d;
        d = ch_data;
        return d[ch*8 +: 8];
    endfunction

    task automatic push_ack(input int ch);
        ack_t a;
        a.ch = ch; a.data = data_of(ch);
        ack_q.push_back(a);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ack"}, 32'(ch_ack), 0);
        chk({tag, "_eng"}, {23'd0, eng_valid, eng_data}, 0);
        chk({tag, "_res"}, {28'd0, res_valid, res_ch, res_anomaly} | 32'(res_timeout), 0);
        chk({tag, "_flags_busy"}, {27'd0, busy, anomaly_flags}, 0);
    endtask

    // Ack monitor: each grant must match the next expected channel/frame
    initial begin
        forever begin
            @(negedge clk);
            if (ch_ack != '0) begin
                if (ack_q.size() == 0) begin
                    chk("ack_unexpected", 32'(ch_ack), 0);
                end else begin
                    ack_t a;
                    a = ack_q.pop_front();
                    $display("ack  ch=%0d ack=%b data=%h", a.ch, ch_ack, eng_data);
                    chk("ack_onehot", 32'($onehot(ch_ack)), 1);
                    chk("ack_ch", 32'(ch_ack), 32'(1) << a.ch);
                    chk("ack_data", 32'(eng_data), 32'(a.data));
                    chk("ack_eng_valid", 32'(eng_valid), 1);
                end
            end
        end
    end

    // Result monitor: each result strobe must match the next expected result
    initial begin
        forever begin
            @(negedge clk);
            if (res_valid) begin
                if (res_q.size() == 0) begin
                    chk("res_unexpected", 32'(res_valid), 0);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    $display("res  ch=%0d anom=%0d to=%0d", res_ch, res_anomaly, res_timeout);
                    chk("res_fields", {29'd0, res_ch, res_anomaly} << 1 | 32'(res_timeout),
                        {29'd0, 2'(r.ch), r.anom} << 1 | 32'(r.to));
                    chk("res_eng_valid_low", 32'(eng_valid), 0);
                end
            end
        end
    end

    // Engine model: wait for the frame, then signal done after delay cycles
    task automatic serve(input int ch, input bit anom, input int delay,
                         input logic [3:0] drop, input logic [3:0] clr);
        res_t r;
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!eng_valid && n < 50);
        if (!eng_valid) begin
            chk("eng_valid_wait", 32'(eng_valid), 1);
            return;
        end
        ch_valid = ch_valid & ~drop;
        repeat (delay) @(negedge clk);
        chk("eng_valid_held", 32'(eng_valid), 1);
        eng_done = 1'b1;
        eng_anomaly = anom;
        r.ch = ch; r.anom = anom; r.to = 1'b0;
        res_q.push_back(r);
        @(negedge clk);
        eng_done = 1'b0;
        eng_anomaly = 1'b0;
        flag_clr = clr;
        @(negedge clk);
        flag_clr = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_zero_outputs("por");
        reset = 1'b1;

        // Single requester with anomaly
        @(negedge clk);
        push_ack(0);
        ch_valid = 4'b0001;
        serve(0, 1'b1, 1, 4'b0001, 4'b0000);
        chk("flags_after_t1", 32'(anomaly_flags), 32'h1);

        // All channels requesting: order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 5; i++) push_ack(i % N_CH);
        ch_valid = 4'b1111;
        for (int i = 0; i < 5; i++) serve(i % N_CH, 1'b0, 2, (i == 4) ? 4'b1111 : 4'b0000, 4'b0000);
        chk("flags_after_t2", 32'(anomaly_flags), 0);

        // Set wins over clear, then clear alone
        push_ack(1);
        ch_valid = 4'b0010;
        serve(1, 1'b1, 1, 4'b0010, 4'b0000);
        chk("flags_set_ch1", 32'(anomaly_flags), 32'h2);
        push_ack(1);
        ch_valid = 4'b0010;
        serve(1, 1'b1, 1, 4'b0010, 4'b0010);
        chk("flags_set_wins", 32'(anomaly_flags), 32'h2);
        flag_clr = 4'b0010;
        @(negedge clk);
        flag_clr = '0;
        chk("flags_cleared", 32'(anomaly_flags), 0);

        // eng_done while idle is ignored
        eng_done = 1'b1;
        eng_anomaly = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_done_ignored", {30'd0, res_valid, busy}, 0);
        end
        eng_done = 1'b0;
        eng_anomaly = 1'b0;
        @(negedge clk);
        chk("idle_done_no_flags", 32'(anomaly_flags), 0);

        // Reset while in S_ISSUE drops the frame; pointer returns to N_CH-1
        push_ack(2);
        ch_valid = 4'b0100;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!eng_valid && n < 50);
            chk("issue_reached", 32'(eng_valid), 1);
        end
        reset = 1'b0;
        ch_valid = '0;
        #1;
        chk_zero_outputs("midrst");
        @(negedge clk);
        reset = 1'b1;
        push_ack(0);
        ch_valid = 4'b1111;
        serve(0, 1'b0, 1, 4'b1111, 4'b0000);

        // Engine never answers
        push_ack(0);
        ch_valid = 4'b0001;
`ifdef ITREE_SCHED_TIMEOUT_EN
        begin
            res_t r;
            int cyc;
            int n;
            r.ch = 0; r.anom = 1'b0; r.to = 1'b1;
            res_q.push_back(r);
            cyc = 0;
            n = 0;
            eng_anomaly = 1'b1;
            while (!res_valid && n < 100) begin
                @(negedge clk);
                n++;
                if (eng_valid) cyc++;
            end
            ch_valid = '0;
            eng_anomaly = 1'b0;
            chk("timeout_cycles", 32'(cyc), 32'(TO_CYC));
            @(negedge clk);
            chk("timeout_flags", 32'(anomaly_flags), 0);
        end
`else
        repeat (40) @(negedge clk);
        ch_valid = '0;
        chk("no_timeout_busy", {30'd0, busy, eng_valid}, 3);
        do_reset();
`endif
        repeat (3) @(negedge clk);
        chk("ack_q_empty", 32'(ack_q.size()), 0);
        chk("res_q_empty", 32'(res_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
